mem_arbiter: RTL and testbench

- Shares the single byte-serial memory controller between three requesters: the instruction cache (fetch), the load/store buffer (load) and the commit path (store).
- Selects one winner by fixed priority, with an optional anti-starvation override, and issues one transaction downstream.
- Waits for completion, then routes read data and a one-cycle ok pulse back to the winner.
- Handles pipeline flush by suppressing responses for squashed fetch/load transactions.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates fetch/load/store onto one byte-serial memory controller (store > load > fetch).
// Define MEM_ARB_STARVE_EN to force a fetch grant after STARVE_LIMIT load/store grants.
module mem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_flush,
  input  logic              in_if_ena,
  input  logic [DATA_W-1:0] in_if_addr,
  output logic              out_if_ok,
  output logic [DATA_W-1:0] out_if_data,
  input  logic              in_ld_ena,
  input  logic [DATA_W-1:0] in_ld_addr,
  input  logic [2:0]        in_ld_size,
  output logic              out_ld_ok,
  output logic [DATA_W-1:0] out_ld_data,
  input  logic              in_st_ena,
  input  logic [DATA_W-1:0] in_st_addr,
  input  logic [2:0]        in_st_size,
  input  logic [DATA_W-1:0] in_st_data,
  output logic              out_st_ok,
  output logic              out_mem_ena,
  output logic              out_mem_is_write,
  output logic [DATA_W-1:0] out_mem_addr,
  output logic [2:0]        out_mem_size,
  output logic [DATA_W-1:0] out_mem_data,
  input  logic              in_mem_busy,
  input  logic              in_mem_done,
  input  logic [DATA_W-1:0] in_mem_data
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {W_NONE, W_IF, W_LD, W_ST} winner_t;

  state_t            state_q, state_d;
  winner_t           winner_q, grant;
  logic              drop_q;
  logic              if_req, ld_req, st_req, force_if;
  logic              issue, done_evt, deliver;
  logic [DATA_W-1:0] sel_addr, sel_data;
  logic [2:0]        sel_size;

  // A requester is masked in its own ok cycle so a still-held level is not re-granted.
  assign if_req = in_if_ena && !out_if_ok && !in_flush;
  assign ld_req = in_ld_ena && !out_ld_ok && !in_flush;
  assign st_req = in_st_ena && !out_st_ok;

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!in_if_ena)
      starve_cnt <= '0;
    else if (issue) begin
      if (grant == W_IF)
        starve_cnt <= '0;
      else if (if_req && starve_cnt != CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] zext(input logic [DATA_W-1:0] d, input logic [2:0] sz);
    case (sz)
      3'd1:    zext = {{(DATA_W-8){1'b0}}, d[7:0]};
      3'd2:    zext = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: zext = d;
    endcase
  endfunction

  always_comb begin
    grant    = W_NONE;
    state_d  = state_q;
    issue    = 1'b0;
    done_evt = 1'b0;
    if (st_req)      grant = W_ST;
    else if (ld_req) grant = W_LD;
    else if (if_req) grant = W_IF;
    if (force_if)    grant = W_IF;
    case (state_q)
      S_IDLE: if (grant != W_NONE && !in_mem_busy) begin
        issue   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (in_mem_done) begin
        done_evt = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_addr = '0;
    sel_size = 3'd0;
    sel_data = '0;
    case (grant)
      W_ST: begin
        sel_addr = in_st_addr;
        sel_size = in_st_size;
        sel_data = in_st_data;
      end
      W_LD: begin
        sel_addr = in_ld_addr;
        sel_size = in_ld_size;
      end
      W_IF: begin
        sel_addr = in_if_addr;
        sel_size = 3'd4;
      end
      default: ;
    endcase
  end

  // A flush coinciding with completion squashes the response just like an earlier one.
  assign deliver = done_evt && !drop_q && !(in_flush && winner_q != W_ST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q         <= W_NONE;
      drop_q           <= 1'b0;
      out_mem_ena      <= 1'b0;
      out_mem_is_write <= 1'b0;
      out_mem_addr     <= '0;
      out_mem_size     <= 3'd0;
      out_mem_data     <= '0;
      out_if_ok        <= 1'b0;
      out_ld_ok        <= 1'b0;
      out_st_ok        <= 1'b0;
      out_if_data      <= '0;
      out_ld_data      <= '0;
    end else begin
      out_mem_ena <= issue;
      out_if_ok   <= 1'b0;
      out_ld_ok   <= 1'b0;
      out_st_ok   <= 1'b0;
      if (issue) begin
        winner_q         <= grant;
        drop_q           <= 1'b0;
        out_mem_is_write <= (grant == W_ST);
        out_mem_addr     <= sel_addr;
        out_mem_size     <= sel_size;
        out_mem_data     <= sel_data;
      end
      if (state_q == S_WAIT) begin
        if (done_evt) begin
          drop_q   <= 1'b0;
          winner_q <= W_NONE;
          if (deliver) begin
            case (winner_q)
              W_IF: begin
                out_if_ok   <= 1'b1;
                out_if_data <= in_mem_data;
              end
              W_LD: begin
                out_ld_ok   <= 1'b1;
                out_ld_data <= zext(in_mem_data, out_mem_size);
              end
              W_ST: out_st_ok <= 1'b1;
              default: ;
            endcase
          end
        end else if (in_flush && winner_q != W_ST) begin
          drop_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus multi-cycle corner sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_flush;
  logic        in_if_ena;
  logic [31:0] in_if_addr;
  logic        out_if_ok;
  logic [31:0] out_if_data;
  logic        in_ld_ena;
  logic [31:0] in_ld_addr;
  logic [2:0]  in_ld_size;
  logic        out_ld_ok;
  logic [31:0] out_ld_data;
  logic        in_st_ena;
  logic [31:0] in_st_addr;
  logic [2:0]  in_st_size;
  logic [31:0] in_st_data;
  logic        out_st_ok;
  logic        out_mem_ena;
  logic        out_mem_is_write;
  logic [31:0] out_mem_addr;
  logic [2:0]  out_mem_size;
  logic [31:0] out_mem_data;
  logic        in_mem_busy;
  logic        in_mem_done;
  logic [31:0] in_mem_data;

  mem_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .in_flush(in_flush),
    .in_if_ena(in_if_ena), .in_if_addr(in_if_addr), .out_if_ok(out_if_ok), .out_if_data(out_if_data),
    .in_ld_ena(in_ld_ena), .in_ld_addr(in_ld_addr), .in_ld_size(in_ld_size),
    .out_ld_ok(out_ld_ok), .out_ld_data(out_ld_data),
    .in_st_ena(in_st_ena), .in_st_addr(in_st_addr), .in_st_size(in_st_size),
    .in_st_data(in_st_data), .out_st_ok(out_st_ok),
    .out_mem_ena(out_mem_ena), .out_mem_is_write(out_mem_is_write), .out_mem_addr(out_mem_addr),
    .out_mem_size(out_mem_size), .out_mem_data(out_mem_data),
    .in_mem_busy(in_mem_busy), .in_mem_done(in_mem_done), .in_mem_data(in_mem_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  req;      // {st, ld, if}
    logic [31:0] f_addr;
    logic [31:0] l_addr;
    logic [2:0]  l_size;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    logic [31:0] s_data;
    logic [31:0] m_data;
    int          dly;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic [31:0] e_mdata;
    logic [2:0]  e_ok;     // {st, ld, if}
    logic [31:0] e_ifd;
    logic [31:0] e_ldd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_issue(input string name);
    for (int i = 0; i < 40 && !out_mem_ena; i++) tick();
    chk({name, " issue"}, {31'd0, out_mem_ena}, 32'd1);
  endtask

  function automatic logic [31:0] oks();
    return {29'd0, out_st_ok, out_ld_ok, out_if_ok};
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, " mem_ena"}, {31'd0, out_mem_ena}, 32'd0);
    chk({name, " is_write"}, {31'd0, out_mem_is_write}, 32'd0);
    chk({name, " mem_addr"}, out_mem_addr, 32'd0);
    chk({name, " mem_size"}, {29'd0, out_mem_size}, 32'd0);
    chk({name, " mem_data"}, out_mem_data, 32'd0);
    chk({name, " oks"}, oks(), 32'd0);
    chk({name, " if_data"}, out_if_data, 32'd0);
    chk({name, " ld_data"}, out_ld_data, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr;
    vecs[0] = '{3'b001, 32'h100, 32'h0,   3'd0, 32'h0,  3'd0, 32'h0,        32'hDEADBEEF, 4,
                1'b0, 32'h100, 3'd4, 32'h0,        3'b001, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{3'b010, 32'h0,   32'h204, 3'd1, 32'h0,  3'd0, 32'h0,        32'h12345678, 1,
                1'b0, 32'h204, 3'd1, 32'h0,        3'b010, 32'hDEADBEEF, 32'h78};
    vecs[2] = '{3'b010, 32'h0,   32'h208, 3'd2, 32'h0,  3'd0, 32'h0,        32'hCAFEF00D, 0,
                1'b0, 32'h208, 3'd2, 32'h0,        3'b010, 32'hDEADBEEF, 32'hF00D};
    vecs[3] = '{3'b100, 32'h0,   32'h0,   3'd0, 32'h20, 3'd1, 32'hAB,       32'hFFFFFFFF, 2,
                1'b1, 32'h20,  3'd1, 32'hAB,       3'b100, 32'hDEADBEEF, 32'hF00D};
    vecs[4] = '{3'b011, 32'h104, 32'h300, 3'd4, 32'h0,  3'd0, 32'h0,        32'h55AA55AA, 3,
                1'b0, 32'h300, 3'd4, 32'h0,        3'b010, 32'hDEADBEEF, 32'h55AA55AA};
    vecs[5] = '{3'b101, 32'h108, 32'h0,   3'd0, 32'h28, 3'd7, 32'h0BADF00D, 32'h0,        1,
                1'b1, 32'h28,  3'd7, 32'h0BADF00D, 3'b100, 32'hDEADBEEF, 32'h55AA55AA};
    vecs[6] = '{3'b001, 32'h10C, 32'h0,   3'd0, 32'h0,  3'd0, 32'h0,        32'h600DCAFE, 2,
                1'b0, 32'h10C, 3'd4, 32'h0,        3'b001, 32'h600DCAFE, 32'h55AA55AA};
    vecs[7] = '{3'b010, 32'h0,   32'h40,  3'd4, 32'h0,  3'd0, 32'h0,        32'hA5A5A5A5, 0,
                1'b0, 32'h40,  3'd4, 32'h0,        3'b010, 32'h600DCAFE, 32'hA5A5A5A5};

    rst = 1'b1; in_flush = 1'b0; in_mem_busy = 1'b0; in_mem_done = 1'b0; in_mem_data = '0;
    in_if_ena = 1'b0; in_if_addr = '0;
    in_ld_ena = 1'b0; in_ld_addr = '0; in_ld_size = '0;
    in_st_ena = 1'b0; in_st_addr = '0; in_st_size = '0; in_st_data = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single transactions from the table
    foreach (vecs[v]) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      {in_st_ena, in_ld_ena, in_if_ena} = vecs[v].req;
      in_if_addr = vecs[v].f_addr;
      in_ld_addr = vecs[v].l_addr; in_ld_size = vecs[v].l_size;
      in_st_addr = vecs[v].s_addr; in_st_size = vecs[v].s_size; in_st_data = vecs[v].s_data;
      wait_issue(nm);
      chk({nm, " is_write"}, {31'd0, out_mem_is_write}, {31'd0, vecs[v].e_wr});
      chk({nm, " addr"}, out_mem_addr, vecs[v].e_addr);
      chk({nm, " size"}, {29'd0, out_mem_size}, {29'd0, vecs[v].e_size});
      chk({nm, " mdata"}, out_mem_data, vecs[v].e_mdata);
      for (int d = 0; d < vecs[v].dly; d++) tick();
      in_mem_done = 1'b1; in_mem_data = vecs[v].m_data;
      tick();
      in_mem_done = 1'b0;
      chk({nm, " ok"}, oks(), {29'd0, vecs[v].e_ok});
      chk({nm, " if_data"}, out_if_data, vecs[v].e_ifd);
      chk({nm, " ld_data"}, out_ld_data, vecs[v].e_ldd);
      {in_st_ena, in_ld_ena, in_if_ena} = 3'b000;
      tick();
      chk({nm, " ok cleared"}, oks(), 32'd0);
      chk({nm, " no reissue"}, {31'd0, out_mem_ena}, 32'd0);
    end

    // Priority: all three at once, each held through its own ok cycle
    in_st_ena = 1'b1; in_st_addr = 32'h20; in_st_size = 3'd1; in_st_data = 32'hAB;
    in_ld_ena = 1'b1; in_ld_addr = 32'h30; in_ld_size = 3'd4;
    in_if_ena = 1'b1; in_if_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      string nm;
      nm = $sformatf("prio%0d", k);
      wait_issue(nm);
      chk({nm, " is_write"}, {31'd0, out_mem_is_write}, (k == 0) ? 32'd1 : 32'd0);
      chk({nm, " addr"}, out_mem_addr, (k == 0) ? 32'h20 : (k == 1) ? 32'h30 : 32'h200);
      tick();
      in_mem_done = 1'b1; in_mem_data = 32'h1000 + k;
      tick();
      in_mem_done = 1'b0;
      chk({nm, " ok"}, oks(), (k == 0) ? 32'd4 : (k == 1) ? 32'd2 : 32'd1);
      tick();
      if (k == 0) in_st_ena = 1'b0;
      else if (k == 1) in_ld_ena = 1'b0;
      else in_if_ena = 1'b0;
    end
    chk("prio masked no regrant", {31'd0, out_mem_ena}, 32'd0);
    chk("prio ld_data", out_ld_data, 32'h1001);
    chk("prio if_data", out_if_data, 32'h1002);
    tick();

    // Flush during WAIT drops the load; a store queued behind it still completes
    in_ld_ena = 1'b1; in_ld_addr = 32'h400; in_ld_size = 3'd4;
    wait_issue("flush ld");
    tick();
    in_flush = 1'b1;
    in_st_ena = 1'b1; in_st_addr = 32'h24; in_st_size = 3'd4; in_st_data = 32'h11223344;
    tick();
    in_flush = 1'b0;
    tick();
    in_mem_done = 1'b1; in_mem_data = 32'h99999999;
    tick();
    in_mem_done = 1'b0;
    chk("flush no ok", oks(), 32'd0);
    chk("flush ld_data held", out_ld_data, 32'h1001);
    in_ld_ena = 1'b0;
    wait_issue("flush st");
    chk("flush st is_write", {31'd0, out_mem_is_write}, 32'd1);
    chk("flush st addr", out_mem_addr, 32'h24);
    chk("flush st data", out_mem_data, 32'h11223344);
    tick();
    in_mem_done = 1'b1;
    tick();
    in_mem_done = 1'b0;
    chk("flush st ok", oks(), 32'd4);
    in_st_ena = 1'b0;
    tick();

    // Completion and flush in the same cycle
    in_ld_ena = 1'b1; in_ld_addr = 32'h404; in_ld_size = 3'd4;
    wait_issue("done+flush");
    tick();
    in_mem_done = 1'b1; in_flush = 1'b1; in_mem_data = 32'h77777777;
    tick();
    in_mem_done = 1'b0; in_flush = 1'b0; in_ld_ena = 1'b0;
    chk("done+flush no ok", oks(), 32'd0);
    chk("done+flush ld_data held", out_ld_data, 32'h1001);
    tick();

    // Busy controller holds off issue; issue follows the cycle busy drops
    in_mem_busy = 1'b1;
    in_if_ena = 1'b1; in_if_addr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("busy hold%0d", i), {31'd0, out_mem_ena}, 32'd0);
    end
    in_mem_busy = 1'b0;
    tick();
    chk("busy release issue", {31'd0, out_mem_ena}, 32'd1);
    chk("busy release addr", out_mem_addr, 32'h500);
    tick();
    in_mem_done = 1'b1; in_mem_data = 32'h5;
    tick();
    in_mem_done = 1'b0;
    chk("busy if ok", oks(), 32'd1);
    chk("busy if_data", out_if_data, 32'h5);
    in_if_ena = 1'b0;
    tick();

    // Load and fetch held continuously; controller busy through each ok cycle
    in_ld_ena = 1'b1; in_ld_addr = 32'h600; in_ld_size = 3'd4;
    in_if_ena = 1'b1; in_if_addr = 32'h700;
    for (int g = 0; g < 10; g++) begin
      string nm;
      nm = $sformatf("starve%0d", g);
      wait_issue(nm);
      in_mem_busy = 1'b1;
`ifdef MEM_ARB_STARVE_EN
      exp_addr = (g % 5 == 4) ? 32'h700 : 32'h600;
`else
      exp_addr = 32'h600;
`endif
      chk({nm, " addr"}, out_mem_addr, exp_addr);
      tick();
      in_mem_done = 1'b1; in_mem_data = 32'h0;
      tick();
      in_mem_done = 1'b0;
      tick();
      in_mem_busy = 1'b0;
    end
    in_ld_ena = 1'b0; in_if_ena = 1'b0;
    tick(); tick();
    if (out_mem_ena) begin
      tick();
      in_mem_done = 1'b1;
      tick();
      in_mem_done = 1'b0;
    end
    tick(); tick();

    // Reset mid-transaction abandons it
    in_if_ena = 1'b1; in_if_addr = 32'h800;
    wait_issue("rst wait");
    tick();
    rst = 1'b1; in_if_ena = 1'b0;
    tick();
    chk_all_zero("rst in wait");
    rst = 1'b0;
    tick();
    in_mem_done = 1'b1; in_mem_data = 32'hBBBBBBBB;
    tick();
    in_mem_done = 1'b0;
    chk("rst late done no ok", oks(), 32'd0);
    chk("rst late done if_data", out_if_data, 32'd0);
    chk("rst late done no issue", {31'd0, out_mem_ena}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
